// File: rtl/dual_issue_ctrl_if.sv
// ID-stage bundle between the IFU, the dual-issue dispatcher and the ALU/memory subpipelines.
// slave = dispatcher side, master = surrounding pipeline / bench side.
interface dual_issue_ctrl_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr0;
  logic [31:0] fetch_instr1;
  logic        fetch_ready;
  logic        alu_valid;
  logic [31:0] alu_pc;
  logic [31:0] alu_instr;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_instr;
  logic        alu_wb_en;
  logic [4:0]  alu_wb_rw;
  logic        mem_wb_en;
  logic [4:0]  mem_wb_rw;
  logic        br_done;
  logic        br_taken;
  logic        issue_stall;

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr0, fetch_instr1,
    input  alu_wb_en, alu_wb_rw, mem_wb_en, mem_wb_rw, br_done, br_taken,
    output fetch_ready, alu_valid, alu_pc, alu_instr,
    output mem_valid, mem_pc, mem_instr, issue_stall
  );

  modport master (
    output fetch_valid, fetch_pc, fetch_instr0, fetch_instr1,
    output alu_wb_en, alu_wb_rw, mem_wb_en, mem_wb_rw, br_done, br_taken,
    input  fetch_ready, alu_valid, alu_pc, alu_instr,
    input  mem_valid, mem_pc, mem_instr, issue_stall
  );
endinterface

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue dispatcher: pair FIFO, per-slot decode, scoreboard,
// branch wait, registered ALU/memory issue ports.

// Per-slot decoder: class plus register usage. Unused operands decode as $0,
// which the scoreboard never marks pending, so they can never cause a hazard.
module dual_issue_dec (
  input  logic [31:0] instr,
  output logic        is_mem,
  output logic        is_br,
  output logic [4:0]  dest,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b
);
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  // opcode -> class / dest / sources
  always_comb begin
    is_mem = 1'b0;
    is_br  = 1'b0;
    dest   = 5'd0;
    src_a  = rs;
    src_b  = rt;
    case (op)
      6'h23: begin is_mem = 1'b1; dest = rt; src_b = 5'd0; end
      6'h2B: is_mem = 1'b1;
      6'h04, 6'h05: is_br = 1'b1;
      6'h07: begin is_br = 1'b1; src_b = 5'd0; end
      6'h00: dest = rd;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin dest = rt; src_b = 5'd0; end
      6'h0F: begin dest = rt; src_a = 5'd0; src_b = 5'd0; end
      default: ;
    endcase
  end
endmodule

module dual_issue_ctrl #(
  parameter int          QDEPTH  = 4,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  dual_issue_ctrl_if.slave bus
);
  localparam int AW    = $clog2(QDEPTH);
  localparam int NSLOT = 2;

  logic [QDEPTH-1:0][31:0] q_pc, q_instr;
  logic [AW-1:0]           head, tail;
  logic [AW:0]             count;
  logic [31:0]             sb;
  logic                    br_wait;

  logic [NSLOT-1:0][AW-1:0] slot_idx;
  logic [NSLOT-1:0][31:0]   slot_pc, slot_instr;
  logic [NSLOT-1:0][4:0]    dest, src_a, src_b;
  logic [NSLOT-1:0]         is_mem, is_br, haz;

  // head and head+1 decode in parallel
  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    assign slot_idx[s]   = head + AW'(s);
    assign slot_pc[s]    = q_pc[slot_idx[s]];
    assign slot_instr[s] = q_instr[slot_idx[s]];
    dual_issue_dec u_dec (
      .instr (slot_instr[s]),
      .is_mem(is_mem[s]),
      .is_br (is_br[s]),
      .dest  (dest[s]),
      .src_a (src_a[s]),
      .src_b (src_b[s])
    );
    // registered (pre-clear) scoreboard; sb[0] is never set
    assign haz[s] = sb[src_a[s]] | sb[src_b[s]] | sb[dest[s]];
  end

  logic iss0, iss1, pair_ok, flush, enq, fetch_ready;
  logic alu_go, mem_go, alu_sel, mem_sel;
  logic [AW:0] n_deq, n_enq;
  logic [31:0] sb_set, sb_clr;

  assign fetch_ready = count <= (AW+1)'(QDEPTH - 2);
  assign flush       = br_wait & bus.br_done & bus.br_taken;
  assign enq         = bus.fetch_valid & fetch_ready & ~flush;

  assign iss0    = (count != '0) & ~br_wait & ~haz[0];
  assign pair_ok = (count >= (AW+1)'(2)) & ~is_br[0] & (is_mem[1] != is_mem[0]) &
                   ~((dest[0] != 5'd0) &
                     ((src_a[1] == dest[0]) | (src_b[1] == dest[0]) | (dest[1] == dest[0])));
  assign iss1    = iss0 & pair_ok & ~haz[1];

  assign n_deq = (AW+1)'(iss0) + (AW+1)'(iss1);
  assign n_enq = enq ? (AW+1)'(2) : '0;

  // slot0 takes its own class port; slot1 is by construction the other class
  assign alu_go  = (iss0 & ~is_mem[0]) | (iss1 & ~is_mem[1]);
  assign mem_go  = (iss0 &  is_mem[0]) | (iss1 &  is_mem[1]);
  assign alu_sel = ~(iss0 & ~is_mem[0]);
  assign mem_sel = ~(iss0 &  is_mem[0]);

  assign sb_set = ((iss0 ? 32'(1) << dest[0] : '0) | (iss1 ? 32'(1) << dest[1] : '0)) & ~32'h1;
  assign sb_clr = (bus.alu_wb_en ? 32'(1) << bus.alu_wb_rw : '0) |
                  (bus.mem_wb_en ? 32'(1) << bus.mem_wb_rw : '0);

  // queue payload; data needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[tail]              <= bus.fetch_pc;
      q_instr[tail]           <= bus.fetch_instr0;
      q_pc[tail + AW'(1)]     <= bus.fetch_pc + PC_STEP;
      q_instr[tail + AW'(1)]  <= bus.fetch_instr1;
    end
  end

  // pointers/occupancy; a taken branch drops everything including a same-edge enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + n_deq[AW-1:0];
      tail  <= tail + n_enq[AW-1:0];
      count <= count + n_enq - n_deq;
    end
  end

  // scoreboard and branch wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb      <= '0;
      br_wait <= 1'b0;
    end else begin
      sb <= (sb & ~sb_clr) | sb_set;
      if (br_wait && bus.br_done)
        br_wait <= 1'b0;
      else if ((iss0 && is_br[0]) || (iss1 && is_br[1]))
        br_wait <= 1'b1;
    end
  end

  logic        alu_valid_q, mem_valid_q;
  logic [31:0] alu_pc_q, alu_instr_q, mem_pc_q, mem_instr_q;

  // registered issue ports; pc/instr hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q <= 1'b0;
      mem_valid_q <= 1'b0;
      alu_pc_q    <= '0;
      alu_instr_q <= '0;
      mem_pc_q    <= '0;
      mem_instr_q <= '0;
    end else begin
      alu_valid_q <= alu_go;
      mem_valid_q <= mem_go;
      if (alu_go) begin
        alu_pc_q    <= slot_pc[alu_sel];
        alu_instr_q <= slot_instr[alu_sel];
      end
      if (mem_go) begin
        mem_pc_q    <= slot_pc[mem_sel];
        mem_instr_q <= slot_instr[mem_sel];
      end
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.issue_stall = (count != '0) & ~iss0;
  assign bus.alu_valid   = alu_valid_q;
  assign bus.alu_pc      = alu_pc_q;
  assign bus.alu_instr   = alu_instr_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_pc      = mem_pc_q;
  assign bus.mem_instr   = mem_instr_q;
endmodule
